fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Parametrised instruction fetch buffer between the prefetch stage (PC/packet generation, ICache request issue) and the decode stage. It holds up to DEPTH fetch packets of FETCH_WIDTH instructions in program order. Each packet is matched to its in-order ICache response, and the buffer discards responses still in flight across a pipeline flush. Completed packets go to decode under a valid/ready handshake.

## Interface
- FETCH_WIDTH, 2, instructions per packet (power of 2, 1..4)
- DEPTH, 8, packet entries (power of 2, ≥2)
- MAX_OUTSTANDING, 2, max ICache requests in flight (≥1)
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush; clears buffer, arms response cancel
- in_valid  in  1  prefetch packet valid
- in_ready  out  1  = (count < DEPTH)
- in_pc  in  32  PC of slot 0, aligned to FETCH_WIDTH*4
- in_mask  in  FETCH_WIDTH  per-slot valid
- in_ex / in_exccode  in  1 / 5  packet-level exception (e.g. AdEL); no ICache request is issued for such packets
- req_issued  in  1  ICache accepted a request (addr_ok) this cycle
- resp_valid  in  1  ICache data_ok; responses in request order, no backpressure
- resp_data  in  32*FETCH_WIDTH  slot i at bits [32i+31:32i]
- resp_tlb_ex / resp_tlb_exccode / resp_tlb_refill  in  1 / 5 / 1  instruction TLB exception for this response
- out_valid  out  1  head packet complete
- out_ready  in  1  decode accepts
- out_pc / out_mask / out_inst  out  32 / FETCH_WIDTH / 32*FETCH_WIDTH  head packet
- out_ex / out_exccode / out_tlb_refill  out  1 / 5 / 1  head packet exception

## Operation
- Circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits). Entry state is FB_WAIT or FB_DONE.
- Enqueue on in_valid && in_ready. Entry gets pc, mask and exception fields.
  - in_ex=1: entry enters FB_DONE, inst=0.
  - Otherwise: entry enters FB_WAIT.
- Response target = oldest valid FB_WAIT entry, searched from head. Only non-cancelled responses are accepted.
- Accepted response: target entry becomes FB_DONE and gets resp_data.
  - If resp_tlb_ex=1: inst=0; ex, exccode and tlb_refill are taken from the response.
  - A response with no FB_WAIT entry is a protocol error: drop it and fire a simulation assertion.
- Dequeue on out_valid && out_ready, where out_valid = count>0 && head entry is FB_DONE. On dequeue, head advances by 1 and the entry is invalidated.
- Enqueue and dequeue in the same cycle: count unchanged. in_ready depends only on registered count; a full buffer does not accept even when dequeuing.
- Outstanding counter: +1 on req_issued, −1 on resp_valid (cancelled or not). Saturation/underflow is an assertion error.
- Cancel counter:
  - On flush it loads outstanding + req_issued − resp_valid, computed with that cycle's inputs.
  - While cancel counter > 0, each resp_valid is discarded and decrements it.
  - A flush while the cancel counter is nonzero reloads it by the same rule.
- Flush has priority over enqueue, dequeue and response write. Entries, pointers and count clear at the next edge. The response in the flush cycle is discarded.
- Reset clears everything, including the outstanding and cancel counters.

## Timing
- Outputs after reset: in_ready=1, out_valid=0, all out_* data=0.
- Latency without bypass:
  - Response to out_valid: 1 cycle, via the entry write.
  - Exception packet: out_valid the cycle after enqueue, if it is at head.
- Throughput: one enqueue, one response and one dequeue per cycle.
- in_ready drops the cycle after count reaches DEPTH.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined: when head entry is FB_WAIT and is the response target, with resp_valid and not cancelled, out_valid=1 in the same cycle and out_inst/exception come from the response.
  - If out_ready is also 1: dequeue directly; the entry is not written to FB_DONE.
  - Otherwise: normal entry write.
- Undefined: no combinational path from resp_* to out_*; 1-cycle latency.

## Structure
- Shared package fetch_buffer_pkg holds:
  - fb_state_e (FB_WAIT, FB_DONE)
  - fb_entry_t (valid, state, pc, mask, inst array, ex, exccode, tlb_refill)
  - fb_exception_t
- Sub-module fb_oldest_wait: rotate-by-head priority encoder over the entry valid/state vectors. Outputs found flag and index.

## Test plan
- Enqueue 3 packets (pc 0x1000, 0x1008, 0x1010), 3 responses, out_ready=1 -> dequeue in order; out_pc 0x1000 appears one cycle after its response.
- Fill 8 packets with out_ready=0 -> in_ready=0 after 8th; one dequeue -> in_ready=1 next cycle; tail wraps to index 0.
- Enqueue pc 0x2000 with in_ex=1, exccode=4, then normal pc 0x2008 -> next response fills 0x2008; out emits 0x2000 with ex=1, inst=0, then 0x2008.
- Response with resp_tlb_ex=1, exccode=2, refill=1 -> out_ex=1, out_exccode=2, out_tlb_refill=1, out_inst=0.
- Two requests in flight, flush with req_issued=1 in the same cycle -> next 3 responses discarded; buffer empty; 4th response fills a new packet.
- Bypass build: empty buffer, one WAIT packet, resp_valid with out_ready=1 -> out_valid in the same cycle, count returns to 0.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared entry/exception types for the fetch buffer
// Holds the entry state enum, the exception record and the buffer entry layout.
// Entry slot arrays are sized for the widest legal packet (FB_MAX_WIDTH); narrower
// builds use the low slots only.
package fetch_buffer_pkg;
  localparam int FB_MAX_WIDTH = 4;
  typedef enum logic {FB_WAIT = 1'b0, FB_DONE = 1'b1} fb_state_e;
  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
    logic       tlb_refill;
  } fb_exception_t;
  typedef struct packed {
    logic                              valid;
    fb_state_e                         state;
    logic [31:0]                       pc;
    logic [FB_MAX_WIDTH-1:0]           mask;
    logic [FB_MAX_WIDTH-1:0][31:0]     inst;
    fb_exception_t                     exc;
  } fb_entry_t;
endpackage

// File: rtl/fb_oldest_wait.sv
// fb_oldest_wait: finds the oldest valid FB_WAIT entry, searching from head
// Ports: head (search start), valid/state (per-entry vectors),
//        found (a waiting entry exists), idx (its index).
module fb_oldest_wait
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [DEPTH-1:0]         valid,
  input  fb_state_e                state [DEPTH],
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] p;
  // Walk from youngest to oldest so the last hit is the one closest to head.
  always_comb begin
    found = 1'b0;
    idx = head;
    p = head;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      p = head + PW'(i);
      if (valid[p] && state[p] == FB_WAIT) begin
        found = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order fetch packet buffer pairing ICache responses with packets
// Ports: clk/reset (sync, active-high), flush (clear + cancel in-flight responses);
//        in_* prefetch packet (valid/ready, pc, mask, packet exception);
//        req_issued (ICache accepted a request); resp_* in-order ICache response;
//        out_* head packet to decode (valid/ready, pc, mask, inst, exception).
// Optional: FETCH_BUFFER_BYPASS_EN forwards a response targeting the head
// straight to out_* in the same cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH     = 2,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [FETCH_WIDTH-1:0]    in_mask,
  input  logic                      in_ex,
  input  logic [4:0]                in_exccode,
  input  logic                      req_issued,
  input  logic                      resp_valid,
  input  logic [32*FETCH_WIDTH-1:0] resp_data,
  input  logic                      resp_tlb_ex,
  input  logic [4:0]                resp_tlb_exccode,
  input  logic                      resp_tlb_refill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [FETCH_WIDTH-1:0]    out_mask,
  output logic [32*FETCH_WIDTH-1:0] out_inst,
  output logic                      out_ex,
  output logic [4:0]                out_exccode,
  output logic                      out_tlb_refill
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  fb_entry_t entries [DEPTH];
  fb_state_e ent_state [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0] head, tail, tgt;
  logic [PW:0] count;
  logic [OW-1:0] outstanding, outstanding_nxt, cancel_cnt;
  logic found, accept, byp, enq, deq, write_resp;
  fb_exception_t resp_exc;
  fb_entry_t new_ent;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_state[i] = entries[i].state;
    end
  end
  fb_oldest_wait #(.DEPTH(DEPTH)) u_oldest (
    .head  (head),
    .valid (ent_valid),
    .state (ent_state),
    .found (found),
    .idx   (tgt)
  );
  // Responses still owed to pre-flush requests are swallowed by the cancel counter.
  assign accept = resp_valid && !flush && cancel_cnt == '0;
`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = accept && found && tgt == head;
`else
  assign byp = 1'b0;
`endif
  assign write_resp = accept && found && !(byp && out_ready);
  assign resp_exc = resp_tlb_ex ? '{ex: 1'b1, exccode: resp_tlb_exccode, tlb_refill: resp_tlb_refill}
                                : entries[tgt].exc;
  assign in_ready = count < (PW+1)'(DEPTH);
  assign out_valid = count != '0 && (entries[head].state == FB_DONE || byp);
  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;
  assign new_ent = '{valid: 1'b1, state: in_ex ? FB_DONE : FB_WAIT, pc: in_pc,
                     mask: FB_MAX_WIDTH'(in_mask), inst: '0,
                     exc: '{ex: in_ex, exccode: in_exccode, tlb_refill: 1'b0}};
  assign out_pc = entries[head].pc;
  assign out_mask = entries[head].mask[FETCH_WIDTH-1:0];
  assign out_inst = byp ? (resp_tlb_ex ? '0 : resp_data) : entries[head].inst[FETCH_WIDTH-1:0];
  assign out_ex = byp ? resp_exc.ex : entries[head].exc.ex;
  assign out_exccode = byp ? resp_exc.exccode : entries[head].exc.exccode;
  assign out_tlb_refill = byp ? resp_exc.tlb_refill : entries[head].exc.tlb_refill;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (write_resp) begin
        entries[tgt].state <= FB_DONE;
        entries[tgt].inst <= resp_tlb_ex ? '0 : (FB_MAX_WIDTH*32)'(resp_data);
        entries[tgt].exc <= resp_exc;
      end
      if (deq) begin
        entries[head].valid <= 1'b0;
        head <= head + PW'(1);
      end
      if (enq) begin
        entries[tail] <= new_ent;
        tail <= tail + PW'(1);
      end
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end
  // A flush must also skip the request accepted in the flush cycle itself.
  assign outstanding_nxt = outstanding + OW'(req_issued) - OW'(resp_valid);
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      cancel_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      cancel_cnt <= flush ? outstanding_nxt
                  : (resp_valid && cancel_cnt != '0) ? cancel_cnt - OW'(1) : cancel_cnt;
    end
  end
  a_resp_target: assert property (@(posedge clk) disable iff (reset) accept |-> found);
  a_out_ovf: assert property (@(posedge clk) disable iff (reset)
    !(req_issued && !resp_valid && outstanding == OW'(MAX_OUTSTANDING)));
  a_out_udf: assert property (@(posedge clk) disable iff (reset) resp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized check of fetch_buffer against a packet-queue model
module tb_fetch_buffer;
  localparam int FW = 2;
  localparam int DEPTH = 8;
  localparam int MAXO = 3;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_ex, req_issued, resp_valid;
  logic resp_tlb_ex, resp_tlb_refill, out_valid, out_ready, out_ex, out_tlb_refill;
  logic [31:0] in_pc, out_pc;
  logic [FW-1:0] in_mask, out_mask;
  logic [4:0] in_exccode, resp_tlb_exccode, out_exccode;
  logic [FW*32-1:0] resp_data, out_inst;
  always #5 clk = ~clk;
  fetch_buffer #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_mask(in_mask),
    .in_ex(in_ex), .in_exccode(in_exccode), .req_issued(req_issued),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tlb_ex(resp_tlb_ex),
    .resp_tlb_exccode(resp_tlb_exccode), .resp_tlb_refill(resp_tlb_refill),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask),
    .out_inst(out_inst), .out_ex(out_ex), .out_exccode(out_exccode),
    .out_tlb_refill(out_tlb_refill)
  );
  typedef struct {
    logic [31:0]      pc;
    logic [FW-1:0]    mask;
    bit               done;
    logic [FW*32-1:0] inst;
    logic             ex;
    logic [4:0]       code;
    logic             refill;
  } pkt_t;
  pkt_t q[$];
  int outst = 0, cancel = 0, n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int wait_cnt();
    int n = 0;
    foreach (q[i]) if (!q[i].done) n++;
    return n;
  endfunction
  // A request is only legal for a waiting packet that has no request yet.
  function automatic bit can_req();
    return outst < MAXO && wait_cnt() - (outst - cancel) > 0;
  endfunction
  function automatic pkt_t filled(pkt_t p);
    pkt_t r = p;
    r.done = 1'b1;
    if (resp_tlb_ex) begin
      r.inst = '0;
      r.ex = 1'b1;
      r.code = resp_tlb_exccode;
      r.refill = resp_tlb_refill;
    end else r.inst = resp_data;
    return r;
  endfunction
  task automatic idle();
    flush = 0; in_valid = 0; in_pc = 0; in_mask = 0; in_ex = 0; in_exccode = 0;
    req_issued = 0; resp_valid = 0; resp_data = 0; resp_tlb_ex = 0;
    resp_tlb_exccode = 0; resp_tlb_refill = 0; out_ready = 0;
  endtask
  task automatic step();
    bit acc, byp, ev, deq, enq;
    int tgt, c_next;
    pkt_t p;
    #1;
    acc = resp_valid && cancel == 0 && !flush;
    tgt = -1;
    foreach (q[i]) if (tgt < 0 && !q[i].done) tgt = i;
    byp = BYP && acc && tgt == 0;
    ev = q.size() > 0 && (q[0].done || byp);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      p = byp ? filled(q[0]) : q[0];
      chk("out_pc", out_pc, p.pc);
      chk("out_mask", out_mask, p.mask);
      chk("out_inst", out_inst, p.inst);
      chk("out_ex", out_ex, p.ex);
      chk("out_exccode", out_exccode, p.code);
      chk("out_tlb_refill", out_tlb_refill, p.refill);
    end
    deq = ev && out_ready;
    enq = in_valid && q.size() < DEPTH;
    if (flush) q.delete();
    else begin
      if (acc && tgt >= 0 && !(byp && out_ready)) q[tgt] = filled(q[tgt]);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back('{in_pc, in_mask, in_ex, '0, in_ex, in_exccode, 1'b0});
    end
    c_next = flush ? outst + int'(req_issued) - int'(resp_valid)
           : (resp_valid && cancel > 0) ? cancel - 1 : cancel;
    outst = outst + int'(req_issued) - int'(resp_valid);
    cancel = c_next;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain(int n);
    repeat (n) begin
      idle();
      out_ready = 1;
      req_issued = can_req();
      resp_valid = outst > 0;
      resp_data = {$urandom(), $urandom()};
      step();
    end
  endtask
  task automatic rnd(int p_in, int p_rdy, int p_fl);
    idle();
    in_valid = $urandom_range(99) < p_in;
    in_pc = $urandom() & ~32'(FW*4-1);
    in_mask = FW'($urandom());
    in_ex = $urandom_range(9) == 0;
    in_exccode = in_ex ? 5'($urandom()) : 5'd0;
    req_issued = can_req() && $urandom_range(1) == 1;
    resp_valid = outst > 0 && $urandom_range(2) != 0;
    resp_data = {$urandom(), $urandom()};
    resp_tlb_ex = $urandom_range(7) == 0;
    resp_tlb_exccode = 5'($urandom());
    resp_tlb_refill = 1'($urandom());
    flush = $urandom_range(99) < p_fl;
    out_ready = $urandom_range(99) < p_rdy;
  endtask
  initial begin
    idle();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_ex", {out_ex, out_exccode, out_tlb_refill, out_mask}, 0);
    @(negedge clk);
    // three packets answered in order
    for (int i = 0; i < 3; i++) begin
      idle(); out_ready = 1; in_valid = 1; in_pc = 32'h1000 + 32'(8*i); in_mask = '1;
      req_issued = can_req(); step();
    end
    drain(6);
    // fill to DEPTH with exception packets, then one dequeue frees a slot
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle(); in_valid = 1; in_pc = 32'h3000 + 32'(8*i); in_mask = '1; in_ex = 1; in_exccode = 5'd4;
      step();
    end
    idle(); in_valid = 1; in_pc = 32'h3100; in_mask = 2'b01; out_ready = 1; step();
    idle(); in_valid = 1; in_pc = 32'h3108; in_mask = 2'b10; in_ex = 1; in_exccode = 5'd4; step();
    drain(DEPTH + 2);
    // exception packet ahead of a normal one
    idle(); in_valid = 1; in_pc = 32'h2000; in_mask = '1; in_ex = 1; in_exccode = 5'd4; step();
    idle(); in_valid = 1; in_pc = 32'h2008; in_mask = '1; step();
    drain(5);
    // TLB exception carried by the response
    idle(); in_valid = 1; in_pc = 32'h2100; in_mask = '1; step();
    idle(); req_issued = can_req(); step();
    idle(); resp_valid = 1; resp_data = {$urandom(), $urandom()};
    resp_tlb_ex = 1; resp_tlb_exccode = 5'd2; resp_tlb_refill = 1; step();
    drain(3);
    // flush with two requests in flight plus one issued in the flush cycle
    for (int i = 0; i < 3; i++) begin
      idle(); in_valid = 1; in_pc = 32'h4000 + 32'(8*i); in_mask = '1; req_issued = can_req(); step();
    end
    idle(); flush = 1; req_issued = can_req(); step();
    repeat (3) begin
      idle(); in_valid = 1; in_pc = 32'h5000; in_mask = '1;
      resp_valid = 1; resp_data = {$urandom(), $urandom()}; step();
    end
    idle(); req_issued = can_req(); step();
    idle(); resp_valid = outst > 0; resp_data = 64'h1111_2222_3333_4444; out_ready = 1; step();
    drain(4);
    repeat (1500) begin rnd(70, 80, 3); step(); end
    repeat (1000) begin rnd(90, 20, 2); step(); end
    repeat (1000) begin rnd(30, 90, 6); step(); end
    drain(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
